// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu - load/store unit between the CPU datapath and a 16-byte,
// word-organised, big-endian data memory.
//
// Accepts one byte/halfword/word load or store at a time. Sub-word stores are
// done as read-modify-write. Load data is extracted from its big-endian lane
// and sign- or zero-extended to 32 bits. Exactly one rsp_valid pulse is
// returned per accepted request.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses return an error response
//   undefined : word accesses use the aligned word, halves use addr[1];
//               only size 2'b11 is an error
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         loads: zero-extend when 1
//   req_addr[3:0]        byte address
//   req_wdata[31:0]      right-justified store data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata[31:0]      extended load data (0 for stores/errors)
//   rsp_err              illegal size or misaligned access
//   mem_addr[3:0]        word-aligned memory address
//   mem_wdata[31:0]      word to write
//   mem_e_read           memory read enable
//   mem_e_write          memory write enable
//   mem_rdata[31:0]      combinational memory read data
// -----------------------------------------------------------------------------
module mem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_e_read,
  output logic        mem_e_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;       // only the sub-word part is needed later
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] rd_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Request error decode. Only feeds registers, so no req_* -> output path.
  always_comb begin
    req_err = (req_size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if (req_size == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  // Big-endian lanes: byte o sits at bit 24-8o, i.e. shift by 8*(3-o).
  assign shamt      = {~off_q, 3'b000};
  assign rd_shifted = mem_rdata >> shamt;
  assign ld_byte    = rd_shifted[7:0];
  // off_q[1] picks the half; off_q[0] is ignored when alignment is unchecked.
  assign ld_half    = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~unsigned_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge: only the addressed lanes are replaced.
  always_comb begin
    if (size_q == 2'b00)
      merged = (mem_rdata & ~(32'h0000_00FF << shamt)) |
               ({24'd0, wdata_q[7:0]} << shamt);
    else if (off_q[1])
      merged = {mem_rdata[31:16], wdata_q};
    else
      merged = {wdata_q, mem_rdata[15:0]};
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          mem_addr_d = {req_addr[3:2], 2'b00};
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = DONE;
          end else if (req_write && req_size == 2'b10) begin
            mem_wdata_d = req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = merged;   // mem_wdata_q doubles as the RMW word buffer
          state_d     = WRITE;
        end else begin
          rsp_rdata_d = ld_ext;
          rsp_err_d   = 1'b0;
          state_d     = DONE;
        end
      end
      WRITE: begin
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'd0;
      mem_addr_q  <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Handshake and enables are pure state decodes.
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign mem_e_read  = (state_q == READ);
  assign mem_e_write = (state_q == WRITE);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [3:0]  req_addr = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_e_read;
  logic        mem_e_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_e_read(mem_e_read), .mem_e_write(mem_e_write), .mem_rdata(mem_rdata)
  );

  // Bench-side memory (word array) driven by the DUT's enables.
  logic [31:0] tb_mem [4];
  logic        mem_init = 1'b0;
  assign mem_rdata = mem_e_read ? tb_mem[mem_addr[3:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4; i++)
        tb_mem[i] <= {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end else if (mem_e_write) begin
      tb_mem[mem_addr[3:2]] <= mem_wdata;
    end
  end

  // Reference model: a plain byte array, address i holds byte i.
  logic [7:0]  ref_mem [16];
  logic [31:0] last_wdata;

  task automatic ref_model(input logic w, input logic [1:0] sz, input logic u,
                           input logic [3:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
    int n;
    int base;
    logic [31:0] v;
    er = 1'b0;
    rd = 32'd0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (sz == 2'b11) er = 1'b1;
    else if (ALIGN && (int'(a) % n) != 0) er = 1'b1;
    if (!er) begin
      base = int'(a) - (int'(a) % n);
      if (w) begin
        for (int k = 0; k < n; k++) ref_mem[base+k] = wd[8*(n-1-k) +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | {24'd0, ref_mem[base+k]};
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  // One full transaction with all per-transaction checks.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                         input logic u, input logic [3:0] a, input logic [31:0] wd,
                         input bit noise);
    logic [31:0] exp_rd, got_rd;
    logic        exp_err, got_err;
    int exp_lat, exp_nr, exp_nw, lat, nr, nw;
    bit overlap, bad_addr, done;
    ref_model(w, sz, u, a, wd, exp_rd, exp_err);
    exp_lat = exp_err ? 1 : (w && sz == 2'b10) ? 2 : w ? 3 : 2;
    exp_nr  = (!exp_err && (!w || sz != 2'b10)) ? 1 : 0;
    exp_nw  = (!exp_err && w) ? 1 : 0;
    lat = 0; nr = 0; nw = 0; overlap = 0; bad_addr = 0; done = 0;
    got_rd = 32'd0; got_err = 1'b0;

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b expected 1", tag, req_ready);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    if (noise) begin
      // A competing store held while busy must be ignored.
      req_write = 1'b1; req_size = 2'b10;
      req_addr = 4'($urandom); req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_e_read) nr++;
      if (mem_e_write) begin nw++; last_wdata = mem_wdata; end
      if (mem_e_read && mem_e_write) overlap = 1;
      if ((mem_e_read || mem_e_write) && mem_addr !== {a[3:2], 2'b00}) bad_addr = 1;
      if (rsp_valid) begin
        done = 1; got_rd = rsp_rdata; got_err = rsp_err; req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout: got no rsp_valid expected within 10 cycles", tag);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if (got_rd !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", tag, got_rd, exp_rd);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++; $display("FAIL %s err: got %b expected %b", tag, got_err, exp_err);
    end
    checks++;
    if (nr != exp_nr || nw != exp_nw) begin
      errors++; $display("FAIL %s enables: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                         tag, nr, nw, exp_nr, exp_nw);
    end
    checks++;
    if (overlap || bad_addr) begin
      errors++; $display("FAIL %s mem_bus: got overlap=%0d bad_addr=%0d expected 0 0",
                         tag, overlap, bad_addr);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
      errors++; $display("FAIL %s hold: got v=%b d=%h e=%b expected v=0 d=%h e=%b",
                         tag, rsp_valid, rsp_rdata, rsp_err, exp_rd, exp_err);
    end
    $display("txn %-10s w=%0d sz=%0d u=%0d a=%0d wd=%h -> rd=%h err=%0d lat=%0d",
             tag, w, sz, u, a, wd, got_rd, got_err, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'd0 || mem_e_read !== 1'b0 || mem_e_write !== 1'b0 ||
        mem_addr !== 4'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL %s reset_outputs: got rdy=%b v=%b e=%b d=%h rd=%b wr=%b a=%h wd=%h expected 1 0 0 0 0 0 0 0",
               tag, req_ready, rsp_valid, rsp_err, rsp_rdata, mem_e_read,
               mem_e_write, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i);
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_clk");
    rst_n = 1'b1;
    mem_init = 1'b0;
  endtask

  task automatic test_directed();
    run_req("ld_w4", 1'b0, 2'b10, 1'b0, 4'd4, 32'd0, 0);
    run_req("st_b2", 1'b1, 2'b00, 1'b0, 4'd2, 32'h80, 0);
    checks++;
    if (last_wdata !== 32'h0001_8003) begin
      errors++; $display("FAIL st_b2 mem_wdata: got %h expected 00018003", last_wdata);
    end
    run_req("ld_b2_s", 1'b0, 2'b00, 1'b0, 4'd2, 32'd0, 0);
    run_req("ld_b2_u", 1'b0, 2'b00, 1'b1, 4'd2, 32'd0, 0);
    run_req("st_h14", 1'b1, 2'b01, 1'b0, 4'd14, 32'hBEEF, 0);
    checks++;
    if (last_wdata !== 32'h0C0D_BEEF) begin
      errors++; $display("FAIL st_h14 mem_wdata: got %h expected 0c0dbeef", last_wdata);
    end
    run_req("ld_h14_s", 1'b0, 2'b01, 1'b0, 4'd14, 32'd0, 0);
    run_req("ld_w12", 1'b0, 2'b10, 1'b0, 4'd12, 32'd0, 0);
  endtask

  task automatic test_errors();
    run_req("ld_w6", 1'b0, 2'b10, 1'b0, 4'd6, 32'd0, 0);
    run_req("ld_h5", 1'b0, 2'b01, 1'b1, 4'd5, 32'd0, 0);
    run_req("ld_sz3", 1'b0, 2'b11, 1'b0, 4'd0, 32'd0, 0);
    run_req("st_sz3", 1'b1, 2'b11, 1'b0, 4'd8, 32'hFFFF_FFFF, 0);
    run_req("st_w9", 1'b1, 2'b10, 1'b0, 4'd9, 32'hA1B2_C3D4, 0);
  endtask

  task automatic test_random(input int n, input bit noise);
    logic [1:0] sz;
    for (int i = 0; i < n; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_req(noise ? "rnd_busy" : "rnd", 1'($urandom_range(0, 1)), sz,
              1'($urandom_range(0, 1)), 4'($urandom), $urandom, noise);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] same;
    same = {24'd0, ref_mem[9]};   // rewrites the existing byte: word unchanged either way
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 4'd9; req_wdata = same;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_e_write !== 1'b1) begin
      errors++; $display("FAIL midop in_write: got %b expected 1", mem_e_write);
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("midop");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn %-10s reset during WRITE of byte store a=9", "midop");
    run_req("after_rst", 1'b0, 2'b10, 1'b0, 4'd8, 32'd0, 0);
  endtask

  task automatic test_mem_compare();
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      exp_w = {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
      checks++;
      if (tb_mem[i] !== exp_w) begin
        errors++; $display("FAIL mem_word%0d: got %h expected %h", i, tb_mem[i], exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_random(60, 0);
    test_random(20, 1);
    test_reset_midop();
    test_mem_compare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
